tx_msg_sequencer: RTL and testbench
===================================

TX_MSG_SEQUENCER -- requirements
Module: tx_msg_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning TX memory, register word and stream width.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 4, meaning TX memory address width (16 words).
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 3, meaning register-file address width.
REQ-004 SHALL have parameter CTRL_ADDR, default 3'd0, meaning the register holding the message length in bits [4:0].
REQ-005 SHALL have parameter STAT_ADDR, default 3'd1, meaning the register receiving the completion status.
REQ-006 SHALL have ports: pclk in 1 (sole clock, rising edge); preset_i in 1 (asynchronous, active-low reset).
REQ-007 SHALL have ports: txreq_i in 1 (transmit request from register file); busy_o out 1 (not IDLE); done_o out 1 (completion pulse); err_o out 1 (sticky length error).
REQ-008 SHALL have ports: mem_addr_o out MEM_ADDR_WIDTH (TX memory read address); mem_re_o out 1 (read enable); mem_data_i in DATA_WIDTH (read data, valid the cycle after mem_re_o).
REQ-009 SHALL have ports: reg_addr_o out REG_ADDR_WIDTH; reg_re_o out 1; reg_we_o out 1; reg_data_o out DATA_WIDTH; reg_data_i in DATA_WIDTH (valid the cycle after reg_re_o).
REQ-010 SHALL have ports: tx_valid_o out 1; tx_ready_i in 1; tx_data_o out DATA_WIDTH; tx_last_o out 1 (final word of message).

Function
REQ-011 SHALL implement states IDLE, RDLEN, LATCH, FETCH, WAIT, SEND, STATUS, REARM.
REQ-012 IDLE -> RDLEN when txreq_i=1 and armed=1; RDLEN drives reg_re_o=1 with reg_addr_o=CTRL_ADDR.
REQ-013 LATCH SHALL capture len=reg_data_i[4:0]; len 1..16 -> FETCH with word counter cleared; len 0 or >16 -> STATUS with err_o set.
REQ-014 FETCH SHALL drive mem_re_o=1 with mem_addr_o=counter; WAIT SHALL register mem_data_i into tx_data_o.
REQ-015 SEND SHALL hold tx_valid_o=1 and tx_data_o stable until tx_ready_i=1; tx_last_o=1 when counter==len-1.
REQ-016 On a SEND handshake, SHALL increment the counter, then go to STATUS if the word was last, else FETCH.
REQ-017 First tx_valid_o SHALL assert 5 cycles after txreq_i is sampled high; each later word takes at least 3 cycles.
REQ-018 Counter SHALL be 5 bits; mem_addr_o = counter[3:0], so word 15 is the highest address and never wraps.
REQ-019 STATUS SHALL pulse reg_we_o=1 and done_o=1 for one cycle with reg_addr_o=STAT_ADDR; reg_data_o = {zeros, count[8:4], 1'b0, abort[2], err[1], 1'b1[0]}.
REQ-020 STATUS SHALL clear armed and go to REARM; REARM -> IDLE, and armed SHALL set only when txreq_i=0, so a held request never retransmits.
REQ-021 reg_re_o, reg_we_o and mem_re_o SHALL never assert in the same cycle.
REQ-022 err_o SHALL clear on the next accepted request.
REQ-023 tx_ready_i outside SEND SHALL be ignored.

Reset
REQ-024 preset_i=0 SHALL asynchronously force IDLE, armed=1, counter=0, len=0, and all outputs 0, including tx_data_o and reg_data_o.
REQ-025 Reset mid-message SHALL abandon the message with no status write; operation resumes on the first pclk edge after preset_i=1.

Configuration
REQ-026 TX_SEQ_ABORT_EN defined SHALL add input abort_i (1 bit).
REQ-027 With TX_SEQ_ABORT_EN, abort_i=1 in RDLEN..SEND SHALL go to STATUS next cycle with status bit2=1, tx_valid_o deasserted, and count equal to the words handshaken.
REQ-028 With TX_SEQ_ABORT_EN, abort_i coinciding with the last handshake SHALL report a normal completion (bit2=0).
REQ-029 Without TX_SEQ_ABORT_EN, the port and logic SHALL be absent and status bit2 SHALL read 0.

Structure
REQ-030 A shared package SHALL hold the state enumeration, CTRL_ADDR/STAT_ADDR defaults, status bit positions and the 16-word maximum length.
REQ-031 No sub-module SHALL be used; the FSM, counter and output registers reside in tx_msg_sequencer.

Verification
REQ-032 Bench SHALL cover: CTRL=3, words A0/A1/A2, tx_ready_i=1 -> three beats, tx_last_o on A2, STAT write 0x31, one done_o.
REQ-033 Bench SHALL cover: CTRL=16 with random tx_ready_i stalls -> data stable while stalled, addresses 0..15, STAT write 0x101.
REQ-034 Bench SHALL cover: CTRL=0 and CTRL=17 -> no mem_re_o, err_o=1, STAT write 0x03.
REQ-035 Bench SHALL cover: txreq_i held high for 100 cycles after done -> exactly one message; drop then raise -> second message.
REQ-036 Bench SHALL cover: preset_i low during 2nd SEND of a 4-word message -> all outputs 0 immediately, no STAT write.
REQ-037 Bench SHALL cover, with TX_SEQ_ABORT_EN: abort_i after 2 of 5 beats -> STAT write 0x25, tx_valid_o low next cycle.

Source files
------------

// File: rtl/tx_msg_sequencer_pkg.sv
// Shared definitions for the TX message sequencer: state encoding, default
// register addresses, status word layout and the maximum message length.
package tx_msg_sequencer_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RDLEN  = 3'd1;
  localparam state_t ST_LATCH  = 3'd2;
  localparam state_t ST_FETCH  = 3'd3;
  localparam state_t ST_WAIT   = 3'd4;
  localparam state_t ST_SEND   = 3'd5;
  localparam state_t ST_STATUS = 3'd6;
  localparam state_t ST_REARM  = 3'd7;

  localparam logic [2:0] CTRL_ADDR_DEFAULT = 3'd0;
  localparam logic [2:0] STAT_ADDR_DEFAULT = 3'd1;

  // Status word layout: bit0 done, bit1 length error, bit2 abort,
  // bit3 reserved, bits 8:4 number of words handshaken.
  localparam int STAT_DONE_BIT  = 0;
  localparam int STAT_ERR_BIT   = 1;
  localparam int STAT_ABORT_BIT = 2;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_WIDTH     = 9;

  localparam logic [4:0] MAX_LEN = 5'd16;

  // Assemble the completion status word written back to the register file.
  function automatic logic [STAT_WIDTH-1:0] pack_status(input logic [4:0] count,
                                                        input logic       abort,
                                                        input logic       err);
    logic [STAT_WIDTH-1:0] s;
    s = '0;
    s[STAT_COUNT_LSB +: 5] = count;
    s[STAT_ABORT_BIT]      = abort;
    s[STAT_ERR_BIT]        = err;
    s[STAT_DONE_BIT]       = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/tx_msg_sequencer.sv
// TX message sequencer: reads a message length from the register file,
// streams that many words from TX memory onto a valid/ready stream, then
// writes a completion status word back to the register file.
// Optional feature macro: TX_SEQ_ABORT_EN adds the abort_i input, which
// cuts a message short and flags the abort in status bit 2.
module tx_msg_sequencer
  import tx_msg_sequencer_pkg::*;
#(
  parameter int                        DATA_WIDTH     = 32,
  parameter int                        MEM_ADDR_WIDTH = 4,
  parameter int                        REG_ADDR_WIDTH = 3,
  parameter logic [REG_ADDR_WIDTH-1:0] CTRL_ADDR      = CTRL_ADDR_DEFAULT,
  parameter logic [REG_ADDR_WIDTH-1:0] STAT_ADDR      = STAT_ADDR_DEFAULT
) (
  input  logic                      pclk,
  input  logic                      preset_i,
`ifdef TX_SEQ_ABORT_EN
  input  logic                      abort_i,
`endif
  input  logic                      txreq_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                      mem_re_o,
  input  logic [DATA_WIDTH-1:0]     mem_data_i,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
  output logic                      reg_re_o,
  output logic                      reg_we_o,
  output logic [DATA_WIDTH-1:0]     reg_data_o,
  input  logic [DATA_WIDTH-1:0]     reg_data_i,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [DATA_WIDTH-1:0]     tx_data_o,
  output logic                      tx_last_o
);

  state_t                state_reg;
  state_t                state_next;
  logic                  armed_reg;
  logic [4:0]            count_reg;
  logic [4:0]            len_reg;
  logic                  err_reg;
  logic                  abort_reg;
  logic [DATA_WIDTH-1:0] tx_data_reg;

  logic accept;
  logic len_ok;
  logic last_word;
  logic handshake;
  logic abort_hit;

  assign accept    = (state_reg == ST_IDLE) && txreq_i && armed_reg;
  assign len_ok    = (reg_data_i[4:0] != 5'd0) && (reg_data_i[4:0] <= MAX_LEN);
  assign last_word = (count_reg == (len_reg - 5'd1));
  assign handshake = (state_reg == ST_SEND) && tx_ready_i;

`ifdef TX_SEQ_ABORT_EN
  // An abort is honoured only while a message is actually in flight.
  assign abort_hit = abort_i && ((state_reg == ST_RDLEN) || (state_reg == ST_LATCH) ||
                                 (state_reg == ST_FETCH) || (state_reg == ST_WAIT)  ||
                                 (state_reg == ST_SEND));

  // Abort flag: a final handshake coinciding with abort counts as normal completion.
  always_ff @(posedge pclk or negedge preset_i) begin
    if (!preset_i) begin
      abort_reg <= 1'b0;
    end else if (accept) begin
      abort_reg <= 1'b0;
    end else if (abort_hit && !(handshake && last_word)) begin
      abort_reg <= 1'b1;
    end
  end
`else
  assign abort_hit = 1'b0;
  assign abort_reg = 1'b0;
`endif

  // Next-state decision for the message sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (accept) state_next = ST_RDLEN;
      ST_RDLEN:  state_next = abort_hit ? ST_STATUS : ST_LATCH;
      ST_LATCH:  state_next = (abort_hit || !len_ok) ? ST_STATUS : ST_FETCH;
      ST_FETCH:  state_next = abort_hit ? ST_STATUS : ST_WAIT;
      ST_WAIT:   state_next = abort_hit ? ST_STATUS : ST_SEND;
      ST_SEND: begin
        if (handshake && last_word) begin
          state_next = ST_STATUS;
        end else if (abort_hit) begin
          state_next = ST_STATUS;
        end else if (handshake) begin
          state_next = ST_FETCH;
        end
      end
      ST_STATUS: state_next = ST_REARM;
      ST_REARM:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register plus the re-arm latch that blocks retransmission on a held request.
  always_ff @(posedge pclk or negedge preset_i) begin
    if (!preset_i) begin
      state_reg <= ST_IDLE;
      armed_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_STATUS) begin
        armed_reg <= 1'b0;
      end else if (!txreq_i) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // Length capture, word counter and sticky length error.
  always_ff @(posedge pclk or negedge preset_i) begin
    if (!preset_i) begin
      count_reg <= 5'd0;
      len_reg   <= 5'd0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        count_reg <= 5'd0;
        err_reg   <= 1'b0;
      end
      if (state_reg == ST_LATCH) begin
        len_reg <= reg_data_i[4:0];
        if (!abort_hit) begin
          if (len_ok) begin
            count_reg <= 5'd0;
          end else begin
            err_reg <= 1'b1;
          end
        end
      end
      if (handshake) begin
        count_reg <= count_reg + 5'd1;
      end
    end
  end

  // Stream data register: loaded from memory, held steady through any stall.
  always_ff @(posedge pclk or negedge preset_i) begin
    if (!preset_i) begin
      tx_data_reg <= '0;
    end else if (state_reg == ST_WAIT) begin
      tx_data_reg <= mem_data_i;
    end
  end

  // Output decode; only one of the three bus strobes is ever active per state.
  always_comb begin
    busy_o     = (state_reg != ST_IDLE);
    done_o     = 1'b0;
    err_o      = err_reg;
    mem_addr_o = '0;
    mem_re_o   = 1'b0;
    reg_addr_o = '0;
    reg_re_o   = 1'b0;
    reg_we_o   = 1'b0;
    reg_data_o = '0;
    tx_valid_o = 1'b0;
    tx_last_o  = 1'b0;
    tx_data_o  = tx_data_reg;
    case (state_reg)
      ST_RDLEN: begin
        reg_re_o   = 1'b1;
        reg_addr_o = CTRL_ADDR;
      end
      ST_FETCH: begin
        mem_re_o   = 1'b1;
        mem_addr_o = MEM_ADDR_WIDTH'(count_reg[3:0]);
      end
      ST_SEND: begin
        tx_valid_o = 1'b1;
        tx_last_o  = last_word;
      end
      ST_STATUS: begin
        reg_we_o   = 1'b1;
        done_o     = 1'b1;
        reg_addr_o = STAT_ADDR;
        reg_data_o = {{(DATA_WIDTH-STAT_WIDTH){1'b0}}, pack_status(count_reg, abort_reg, err_reg)};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_msg_sequencer.sv
// Directed testbench for tx_msg_sequencer with behavioural TX memory and
// register-file models (both with one-cycle registered read).
module tb_tx_msg_sequencer;

  localparam int DW = 32;

  logic          pclk       = 1'b0;
  logic          preset_i   = 1'b1;
  logic          txreq_i    = 1'b0;
  logic          tx_ready_i = 1'b0;
`ifdef TX_SEQ_ABORT_EN
  logic          abort_i    = 1'b0;
`endif
  logic          busy_o, done_o, err_o, mem_re_o, reg_re_o, reg_we_o, tx_valid_o, tx_last_o;
  logic [3:0]    mem_addr_o;
  logic [2:0]    reg_addr_o;
  logic [DW-1:0] mem_data_i = '0;
  logic [DW-1:0] reg_data_i = '0;
  logic [DW-1:0] reg_data_o, tx_data_o;

  logic [DW-1:0] mem  [16];
  logic [DW-1:0] regs [8];

  int checks = 0;
  int errors = 0;

  // monitor bookkeeping
  int            cyc = 0, beats = 0, done_count = 0, stat_writes = 0, mem_reads = 0, overlap = 0;
  logic [DW-1:0] stat_value = '0;
  logic [2:0]    stat_addr  = '0;
  logic [DW-1:0] beat_data[$];
  logic          beat_last[$];
  int            beat_cyc[$];
  logic [3:0]    read_addr[$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic          stall_check = 1'b0;
  logic          rand_ready  = 1'b0;

  tx_msg_sequencer dut (
    .pclk       (pclk),
    .preset_i   (preset_i),
`ifdef TX_SEQ_ABORT_EN
    .abort_i    (abort_i),
`endif
    .txreq_i    (txreq_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mem_addr_o (mem_addr_o),
    .mem_re_o   (mem_re_o),
    .mem_data_i (mem_data_i),
    .reg_addr_o (reg_addr_o),
    .reg_re_o   (reg_re_o),
    .reg_we_o   (reg_we_o),
    .reg_data_o (reg_data_o),
    .reg_data_i (reg_data_i),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .tx_data_o  (tx_data_o),
    .tx_last_o  (tx_last_o)
  );

  always #5 pclk = ~pclk;

  // memory and register-file models
  always @(posedge pclk) begin
    if (mem_re_o) mem_data_i <= mem[mem_addr_o];
    if (reg_re_o) reg_data_i <= regs[reg_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic monitor_sample();
    cyc++;
    if ((int'(reg_re_o) + int'(reg_we_o) + int'(mem_re_o)) > 1) overlap++;
    if (stall_check && prev_stall) begin
      check("stall_valid", {31'd0, tx_valid_o}, 32'd1);
      check("stall_data", tx_data_o, prev_data);
    end
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;
    if (tx_valid_o && tx_ready_i && preset_i) begin
      beats++;
      beat_data.push_back(tx_data_o);
      beat_last.push_back(tx_last_o);
      beat_cyc.push_back(cyc);
      $display("beat %0d: data=0x%08h last=%0b", beats, tx_data_o, tx_last_o);
    end
    if (mem_re_o) begin
      mem_reads++;
      read_addr.push_back(mem_addr_o);
    end
    if (done_o) done_count++;
    if (reg_we_o) begin
      stat_writes++;
      stat_value = reg_data_o;
      stat_addr  = reg_addr_o;
      $display("status write: addr=%0d data=0x%03h", reg_addr_o, reg_data_o);
    end
  endtask

  initial forever begin
    @(negedge pclk);
    monitor_sample();
  end

  task automatic step();
    @(posedge pclk);
    #1;
    if (rand_ready) tx_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_logs();
    beats = 0; done_count = 0; stat_writes = 0; mem_reads = 0;
    stat_value = '0; stat_addr = '0;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete(); read_addr.delete();
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      step();
      n++;
    end
    if (done_count == start) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic release_req();
    txreq_i = 1'b0;
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     {31'd0, busy_o},     32'd0);
    check({tag, "_done"},     {31'd0, done_o},     32'd0);
    check({tag, "_err"},      {31'd0, err_o},      32'd0);
    check({tag, "_valid"},    {31'd0, tx_valid_o}, 32'd0);
    check({tag, "_last"},     {31'd0, tx_last_o},  32'd0);
    check({tag, "_mem_re"},   {31'd0, mem_re_o},   32'd0);
    check({tag, "_reg_re"},   {31'd0, reg_re_o},   32'd0);
    check({tag, "_reg_we"},   {31'd0, reg_we_o},   32'd0);
    check({tag, "_mem_addr"}, {28'd0, mem_addr_o}, 32'd0);
    check({tag, "_reg_addr"}, {29'd0, reg_addr_o}, 32'd0);
    check({tag, "_tx_data"},  tx_data_o,           32'd0);
    check({tag, "_reg_data"}, reg_data_o,          32'd0);
  endtask

  initial begin
    int n;
    int lasts;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 8; i++) regs[i] = '0;

    // asynchronous reset before any clock edge
    #2 preset_i = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge pclk);
    #1 preset_i = 1'b1;
    step();

    // three-word message, ready always high
    clear_logs();
    regs[0] = 32'd3;
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2;
    tx_ready_i = 1'b1;
    txreq_i = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!tx_valid_o && n < 20);
    check("first_valid_latency", n, 32'd5);
    wait_done(50);
    check("m3_beats", beats, 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("m3_data", beat_data[i], 32'hA0 + i);
      check("m3_last", {31'd0, beat_last[i]}, (i == 2) ? 32'd1 : 32'd0);
      check("m3_addr", {28'd0, read_addr[i]}, i);
    end
    check("m3_word_spacing", beat_cyc[1] - beat_cyc[0], 32'd3);
    check("m3_mem_reads", mem_reads, 32'd3);
    check("m3_status", stat_value, 32'h31);
    check("m3_stat_addr", {29'd0, stat_addr}, 32'd1);
    check("m3_done_count", done_count, 32'd1);
    check("m3_err", {31'd0, err_o}, 32'd0);
    release_req();

    // sixteen-word message with random backpressure
    clear_logs();
    regs[0] = 32'd16;
    for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 + i * 32'h11;
    rand_ready = 1'b1;
    stall_check = 1'b1;
    txreq_i = 1'b1;
    wait_done(2000);
    rand_ready = 1'b0;
    stall_check = 1'b0;
    tx_ready_i = 1'b1;
    check("m16_beats", beats, 32'd16);
    lasts = 0;
    for (int i = 0; i < 16; i++) begin
      check("m16_data", beat_data[i], 32'h5A00_0000 + i * 32'h11);
      check("m16_addr", {28'd0, read_addr[i]}, i);
      if (beat_last[i]) lasts++;
    end
    check("m16_last_count", lasts, 32'd1);
    check("m16_last_final", {31'd0, beat_last[15]}, 32'd1);
    check("m16_status", stat_value, 32'h101);
    release_req();

    // zero length: error, no memory traffic
    clear_logs();
    regs[0] = 32'd0;
    txreq_i = 1'b1;
    wait_done(50);
    check("len0_mem_reads", mem_reads, 32'd0);
    check("len0_err", {31'd0, err_o}, 32'd1);
    check("len0_status", stat_value, 32'h03);
    check("len0_beats", beats, 32'd0);
    release_req();
    check("err_sticky", {31'd0, err_o}, 32'd1);

    // length 17: error cleared on acceptance, then set again
    clear_logs();
    regs[0] = 32'd17;
    txreq_i = 1'b1;
    step();
    check("err_clear_on_accept", {31'd0, err_o}, 32'd0);
    wait_done(50);
    check("len17_mem_reads", mem_reads, 32'd0);
    check("len17_err", {31'd0, err_o}, 32'd1);
    check("len17_status", stat_value, 32'h03);
    release_req();

    // held request produces exactly one message
    clear_logs();
    regs[0] = 32'd2;
    mem[0] = 32'hC0; mem[1] = 32'hC1;
    txreq_i = 1'b1;
    wait_done(50);
    repeat (100) step();
    check("held_done_count", done_count, 32'd1);
    check("held_beats", beats, 32'd2);
    check("held_idle", {31'd0, busy_o}, 32'd0);
    txreq_i = 1'b0;
    step();
    step();
    txreq_i = 1'b1;
    wait_done(50);
    check("rearm_done_count", done_count, 32'd2);
    check("rearm_status", stat_value, 32'h21);
    release_req();

    // reset during the second SEND of a four-word message
    clear_logs();
    regs[0] = 32'd4;
    mem[0] = 32'hB0; mem[1] = 32'hB1; mem[2] = 32'hB2; mem[3] = 32'hB3;
    txreq_i = 1'b1;
    n = 0;
    while (beats < 1 && n < 50) begin step(); n++; end
    n = 0;
    while (!tx_valid_o && n < 20) begin step(); n++; end
    check("rst_reached_send2", {31'd0, tx_valid_o}, 32'd1);
    preset_i = 1'b0;
    #1 check_all_zero("midrst");
    repeat (3) step();
    preset_i = 1'b1;
    check("rst_no_stat_write", stat_writes, 32'd0);
    check("rst_no_done", done_count, 32'd0);
    step();
    check("resume_first_edge", {31'd0, busy_o}, 32'd1);
    wait_done(100);
    check("resume_status", stat_value, 32'h41);
    check("resume_stat_writes", stat_writes, 32'd1);
    release_req();

`ifdef TX_SEQ_ABORT_EN
    // abort after two of five beats
    clear_logs();
    regs[0] = 32'd5;
    for (int i = 0; i < 5; i++) mem[i] = 32'hD0 + i;
    tx_ready_i = 1'b1;
    txreq_i = 1'b1;
    n = 0;
    while (beats < 2 && n < 50) begin step(); n++; end
    tx_ready_i = 1'b0;
    n = 0;
    while (!tx_valid_o && n < 20) begin step(); n++; end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("abort_valid_low", {31'd0, tx_valid_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd1);
    check("abort_reg_data", reg_data_o, 32'h25);
    step();
    check("abort_status", stat_value, 32'h25);
    check("abort_beats", beats, 32'd2);
    tx_ready_i = 1'b1;
    release_req();
`endif

    check("strobe_overlap", overlap, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
